// File: rtl/secret_check.sv
// secret_check: scoreboard for the upstream accumulator/passthrough stage.
// It snoops that stage's inputs and outputs, keeps its own model of them, and checks
// the outputs against the model for NUM_CHECKS cycles after each start pulse.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                one-cycle pulse; arms a run from IDLE or DONE (ignored in RUN)
//   accum_in, accum_out  accumulator input and registered output of the upstream stage
//   sig_in, sig_out      packed passthrough bus {s129,s65,s64,s33,s8,s2,s1}, in and out
//   busy, done, pass     run status; pass is meaningful only while done is high
//   acc_err, sig_err     sticky mismatch flags for the current run
//   err_cnt              number of mismatching check cycles, saturating at all-ones
//   first_err_idx        0-based index of the first failing check, 16'hFFFF if none
module secret_check #(
    parameter int ACC_W      = 32,
    parameter int SIG_W      = 302,
    parameter int NUM_CHECKS = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] accum_in,
    input  logic [ACC_W-1:0] accum_out,
    input  logic [SIG_W-1:0] sig_in,
    input  logic [SIG_W-1:0] sig_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             acc_err,
    output logic             sig_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      first_err_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [ACC_W-1:0] model_acc;
    logic [SIG_W-1:0] exp_sig;
    logic [15:0]      chk_idx;

    logic             acc_mis;
    logic             sig_mis;
    logic             any_mis;
    logic             last_chk;
    logic             launch;
    logic [CNT_W-1:0] err_cnt_nxt;

    always_comb begin
        // Case inequality so that any X/Z bit on the snooped outputs is a mismatch.
        acc_mis     = (accum_out !== model_acc);
        sig_mis     = (sig_out !== exp_sig);
        any_mis     = acc_mis | sig_mis;
        last_chk    = (chk_idx == 16'(NUM_CHECKS - 1));
        launch      = start && (state != RUN);

        // One count per failing cycle, even if both acc and sig mismatch.
        err_cnt_nxt = err_cnt;
        if (any_mis && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end

        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)    state_nxt = RUN;
            RUN:        if (last_chk) state_nxt = DONE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= state_nxt;
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            acc_err       <= 1'b0;
            sig_err       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= 16'hFFFF;
            model_acc     <= '0;
            exp_sig       <= '0;
            chk_idx       <= '0;
        end else if (launch) begin
            // Seed: the upstream output one edge from now is accum_out + accum_in.
            model_acc     <= accum_out + accum_in;
            exp_sig       <= sig_in;
            chk_idx       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            acc_err       <= 1'b0;
            sig_err       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= 16'hFFFF;
        end else if (state == RUN) begin
            err_cnt <= err_cnt_nxt;
            if (acc_mis) acc_err <= 1'b1;
            if (sig_mis) sig_err <= 1'b1;
            if (any_mis && (first_err_idx == 16'hFFFF)) begin
                first_err_idx <= chk_idx;
            end
            model_acc <= model_acc + accum_in;
            exp_sig   <= sig_in;
            chk_idx   <= chk_idx + 16'd1;
            if (last_chk) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_secret_check.sv
module tb_secret_check;

    localparam int ACC_W = 32;
    localparam int SIG_W = 302;
    localparam int N     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ACC_W-1:0] accum_in;
    logic [ACC_W-1:0] accum_out;
    logic [SIG_W-1:0] sig_in;
    logic [SIG_W-1:0] sig_out;

    logic        busy, done, pass, acc_err, sig_err;
    logic [7:0]  err_cnt;
    logic [15:0] first_err_idx;
    logic        busy4, done4, pass4, acc_err4, sig_err4;
    logic [3:0]  err_cnt4;
    logic [15:0] first_err_idx4;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus for one run; index 0 is the start edge, index i+1 is check i.
    logic [ACC_W-1:0] ain  [0:N];
    logic [ACC_W-1:0] aout [0:N];
    logic [SIG_W-1:0] sin  [0:N];
    logic [SIG_W-1:0] sout [0:N];
    bit               mid_start [0:N];

    always #5 clk = ~clk;

    secret_check #(.ACC_W(ACC_W), .SIG_W(SIG_W), .NUM_CHECKS(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .accum_in(accum_in), .accum_out(accum_out), .sig_in(sig_in), .sig_out(sig_out),
        .busy(busy), .done(done), .pass(pass), .acc_err(acc_err), .sig_err(sig_err),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    secret_check #(.ACC_W(ACC_W), .SIG_W(SIG_W), .NUM_CHECKS(N), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
        .accum_in(accum_in), .accum_out(accum_out), .sig_in(sig_in), .sig_out(sig_out),
        .busy(busy4), .done(done4), .pass(pass4), .acc_err(acc_err4), .sig_err(sig_err4),
        .err_cnt(err_cnt4), .first_err_idx(first_err_idx4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIG_W-1:0] rand_sig();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return t[SIG_W-1:0];
    endfunction

    // Well-behaved upstream stage: registered passthrough and accumulator.
    task automatic build_clean(input logic [ACC_W-1:0] seed, input bit rnd_in,
                               input logic [ACC_W-1:0] inc);
        aout[0] = seed;
        sout[0] = rand_sig();
        for (int c = 0; c <= N; c++) begin
            ain[c]       = rnd_in ? ACC_W'($urandom) : inc;
            sin[c]       = rand_sig();
            mid_start[c] = 1'b0;
        end
        for (int c = 1; c <= N; c++) begin
            aout[c] = aout[c-1] + ain[c-1];
            sout[c] = sin[c-1];
        end
    endtask

    task automatic drive(input int c);
        accum_in  = ain[c];
        accum_out = aout[c];
        sig_in    = sin[c];
        sig_out   = sout[c];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the stored stimulus and compares every status output with the expectation
    // derived from the stage's defining rule: check i expects
    //   accum_out = seed + sum(accum_in[0..i]),  sig_out = sig_in[i].
    task automatic run_and_check(input string tag);
        int          errs;
        int          first;
        bit          ae, se, am, sm;
        logic [31:0] acc;
        errs  = 0;
        first = 16'hFFFF;
        ae    = 0;
        se    = 0;
        acc   = aout[0];
        for (int i = 0; i < N; i++) begin
            acc = acc + ain[i];
            am  = (aout[i+1] !== acc);
            sm  = (sout[i+1] !== sin[i]);
            if (am || sm) begin
                if (errs == 0) first = i;
                errs++;
            end
            ae |= am;
            se |= sm;
        end

        drive(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_busy"}, {30'd0, busy, done}, 32'b10);
        for (int c = 1; c <= N; c++) begin
            drive(c);
            start = mid_start[c];
            tick();
            start = 1'b0;
            if (c < N) chk({tag, "_run_busy"}, {30'd0, busy, done}, 32'b10);
        end
        chk({tag, "_done"},      {30'd0, busy, done}, 32'b01);
        chk({tag, "_pass"},      32'(pass), 32'(errs == 0));
        chk({tag, "_acc_err"},   32'(acc_err), 32'(ae));
        chk({tag, "_sig_err"},   32'(sig_err), 32'(se));
        chk({tag, "_err_cnt"},   32'(err_cnt), (errs > 255) ? 32'd255 : 32'(errs));
        chk({tag, "_err_cnt4"},  32'(err_cnt4), (errs > 15) ? 32'd15 : 32'(errs));
        chk({tag, "_first"},     32'(first_err_idx), 32'(first));
        chk({tag, "_first4"},    32'(first_err_idx4), 32'(first));
        chk({tag, "_pass4"},     32'(pass4), 32'(errs == 0));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        accum_in = '0;
        accum_out = '0;
        sig_in = '0;
        sig_out = '0;
        tick();
        tick();
        chk("reset_status", {27'd0, busy, done, pass, acc_err, sig_err}, 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_first", 32'(first_err_idx), 32'hFFFF);
        rst = 1'b0;
        tick();

        // Clean run, accum_in=1, with a stray start in the middle.
        build_clean(32'd100, 1'b0, 32'd1);
        mid_start[6] = 1'b1;
        run_and_check("clean");

        // Outputs hold while DONE and idle.
        for (int k = 0; k < 3; k++) tick();
        chk("hold_done", {29'd0, busy, done, pass}, 32'b011);

        // Accumulator wrap-around.
        build_clean(32'hFFFF_FFFE, 1'b0, 32'd1);
        run_and_check("wrap");

        // s129 bit 128 (bus bit 301) flipped at check 5 only.
        build_clean(32'h1234_5678, 1'b1, 32'd0);
        sout[6][301] = ~sout[6][301];
        run_and_check("sigflip");

        // Accumulator sticks at 0 after check 0: 15 failures, first at 1.
        build_clean(32'd0, 1'b0, 32'd3);
        for (int c = 2; c <= N; c++) aout[c] = '0;
        run_and_check("stuck");

        // Every check fails: 16 errors, narrow counter saturates.
        build_clean(32'd0, 1'b0, 32'd3);
        for (int c = 1; c <= N; c++) aout[c] = '0;
        run_and_check("allbad");

        // Random upstream traffic with sparse random faults.
        for (int r = 0; r < 6; r++) begin
            build_clean(ACC_W'($urandom), 1'b1, 32'd0);
            for (int c = 1; c <= N; c++) begin
                if ($urandom_range(0, 9) == 0) aout[c][$urandom_range(0, ACC_W-1)] ^= 1'b1;
                if ($urandom_range(0, 9) == 0) sout[c][$urandom_range(0, SIG_W-1)] ^= 1'b1;
                mid_start[c] = ($urandom_range(0, 7) == 0);
            end
            run_and_check("random");
        end

        // Reset at check 8 aborts the run.
        build_clean(32'd7, 1'b1, 32'd0);
        for (int c = 2; c <= N; c++) aout[c] = '0;
        drive(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            drive(c);
            tick();
        end
        drive(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_status", {30'd0, busy, done}, 32'd0);
        chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_mid_first", 32'(first_err_idx), 32'hFFFF);
        for (int k = 0; k < 3; k++) tick();
        chk("rst_mid_idle", {30'd0, busy, done}, 32'd0);

        build_clean(32'd55, 1'b1, 32'd0);
        run_and_check("after_rst");

        // rst wins over a simultaneous start.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_status", {29'd0, busy, done, pass}, 32'd0);
        tick();
        chk("rst_start_idle", {30'd0, busy, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
